// File: rtl/matrix_sum_serializer_pkg.sv
// ============================================================================
// Module : matrix_sum_serializer_pkg
// Brief  : Shared sizes, index widths and read-FSM state type for the
//          matrix sum serializer. Output saturation is enabled by defining
//          MATRIX_SUM_SAT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package matrix_sum_serializer_pkg;

    localparam int c_ROWS  = 10;
    localparam int c_COLS  = 12;
    localparam int c_ROW_W = 4;
    localparam int c_COL_W = 4;

`ifdef MATRIX_SUM_SAT_EN
    localparam bit c_SAT_EN = 1'b1;
`else
    localparam bit c_SAT_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } rdState_t;

    // Saturation trims the sign-growth bit off each sum.
    function automatic int outWidth(input int inWidth);
        return c_SAT_EN ? inWidth : inWidth + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_sum_serializer_if.sv
// ============================================================================
// Module : matrix_sum_serializer_if
// Brief  : Row-input / element-output bundle of the matrix sum serializer.
//          Output width depends on MATRIX_SUM_SAT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface matrix_sum_serializer_if
    import matrix_sum_serializer_pkg::*;
#(
    parameter int IN_WIDTH = 10,
    parameter int COLS     = c_COLS
) ();

    localparam int OUT_W = outWidth(IN_WIDTH);

    logic                           enable;
    logic                           in_valid;
    logic [c_ROW_W-1:0]             in_row_no;
    logic [COLS*(IN_WIDTH+1)-1:0]   in_sums;
    logic                           out_valid;
    logic                           out_ready;
    logic [OUT_W-1:0]               out_data;
    logic [c_ROW_W-1:0]             out_row;
    logic [c_COL_W-1:0]             out_col;
    logic                           out_last;
    logic                           overflow;
    logic                           seq_err;

    modport slave (
        input  enable, in_valid, in_row_no, in_sums, out_ready,
        output out_valid, out_data, out_row, out_col, out_last, overflow, seq_err
    );

    modport master (
        output enable, in_valid, in_row_no, in_sums, out_ready,
        input  out_valid, out_data, out_row, out_col, out_last, overflow, seq_err
    );

endinterface

`default_nettype wire

// File: rtl/matrix_sum_serializer_bank.sv
// ============================================================================
// Module : matrix_sum_bank
// Brief  : One ROWS x COLS bank of signed sums; whole-row write port and
//          combinational single-element read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module matrix_sum_bank
    import matrix_sum_serializer_pkg::*;
#(
    parameter int IN_WIDTH = 10,
    parameter int ROWS     = c_ROWS,
    parameter int COLS     = c_COLS
) (
    input  wire logic                         clk,
    input  wire logic                         i_wrEn,
    input  wire logic [c_ROW_W-1:0]           i_wrRow,
    input  wire logic [COLS*(IN_WIDTH+1)-1:0] i_wrData,
    input  wire logic [c_ROW_W-1:0]           i_rdRow,
    input  wire logic [c_COL_W-1:0]           i_rdCol,
    output logic      [IN_WIDTH:0]            o_rdData
);

    localparam int SW = IN_WIDTH + 1;

    logic [COLS*SW-1:0] r_mem [ROWS];
    logic [COLS*SW-1:0] w_rowWord;

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrRow] <= i_wrData;
        end
    end

    assign w_rowWord = r_mem[i_rdRow];
    assign o_rdData  = w_rowWord[i_rdCol*SW +: SW];

endmodule

`default_nettype wire

// File: rtl/matrix_sum_serializer.sv
// ============================================================================
// Module : matrix_sum_serializer
// Brief  : Ping-pong buffers rows of sums and streams them out row-major with
//          valid/ready. MATRIX_SUM_SAT_EN saturates outputs to IN_WIDTH bits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module matrix_sum_serializer
    import matrix_sum_serializer_pkg::*;
#(
    parameter int IN_WIDTH = 10,
    parameter int ROWS     = c_ROWS,
    parameter int COLS     = c_COLS
) (
    input  wire logic           clk,
    input  wire logic           reset,
    matrix_sum_serializer_if.slave bus
);

    localparam int SW    = IN_WIDTH + 1;
    localparam int OUT_W = outWidth(IN_WIDTH);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(ROWS - 1);
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(COLS - 1);

    logic [c_ROW_W-1:0] r_expRow;
    logic               r_wrBank;
    logic [1:0]         r_full;
    logic               r_rdBank;
    rdState_t           r_state;
    logic [c_ROW_W-1:0] r_rdRow;
    logic [c_COL_W-1:0] r_rdCol;
    logic               r_outValid;
    logic [OUT_W-1:0]   r_outData;
    logic               r_outLast;
    logic               r_overflow;
    logic               r_seqErr;

    logic               w_rowIn;
    logic               w_inOrder;
    logic               w_wrEn;
    logic               w_fillDone;
    logic               w_handshake;
    logic               w_drainDone;
    logic               w_rdSel;
    logic [c_ROW_W-1:0] w_nextRow;
    logic [c_COL_W-1:0] w_nextCol;
    logic               w_nextLast;
    logic [SW-1:0]      w_bankData [2];
    logic [OUT_W-1:0]   w_outElem;

    function automatic logic [OUT_W-1:0] fnOut(input logic [SW-1:0] s);
`ifdef MATRIX_SUM_SAT_EN
        // Top two bits disagree exactly when the sum leaves the IN_WIDTH range.
        if (s[SW-1] != s[SW-2]) begin
            return s[SW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
        return s[OUT_W-1:0];
`else
        return s;
`endif
    endfunction

    assign w_rowIn     = bus.enable && bus.in_valid;
    assign w_inOrder   = (bus.in_row_no == '0) || (bus.in_row_no == r_expRow);
    assign w_wrEn      = w_rowIn && !r_full[r_wrBank] && w_inOrder;
    assign w_fillDone  = w_wrEn && (bus.in_row_no == c_LAST_ROW);
    assign w_handshake = bus.enable && r_outValid && bus.out_ready;
    assign w_drainDone = w_handshake && r_outLast;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            matrix_sum_bank #(
                .IN_WIDTH (IN_WIDTH),
                .ROWS     (ROWS),
                .COLS     (COLS)
            ) u_bank (
                .clk      (clk),
                .i_wrEn   (w_wrEn && (r_wrBank == 1'(b))),
                .i_wrRow  (bus.in_row_no),
                .i_wrData (bus.in_sums),
                .i_rdRow  (w_nextRow),
                .i_rdCol  (w_nextCol),
                .o_rdData (w_bankData[b])
            );
        end
    endgenerate

    // Address of the element to present after the next state change.
    always_comb begin
        w_rdSel   = r_rdBank;
        w_nextRow = '0;
        w_nextCol = '0;
        if (r_state == ST_DRAIN) begin
            if (r_outLast) begin
                w_rdSel = ~r_rdBank;
            end else if (r_rdCol == c_LAST_COL) begin
                w_nextRow = r_rdRow + 1'b1;
            end else begin
                w_nextRow = r_rdRow;
                w_nextCol = r_rdCol + 1'b1;
            end
        end
    end

    assign w_nextLast = (w_nextRow == c_LAST_ROW) && (w_nextCol == c_LAST_COL);
    assign w_outElem  = fnOut(w_bankData[w_rdSel]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_expRow   <= '0;
            r_wrBank   <= 1'b0;
            r_overflow <= 1'b0;
            r_seqErr   <= 1'b0;
        end else if (w_rowIn) begin
            if (r_full[r_wrBank]) begin
                r_overflow <= 1'b1;
            end else if (w_inOrder) begin
                if (w_fillDone) begin
                    r_expRow <= '0;
                    r_wrBank <= ~r_wrBank;
                end else begin
                    r_expRow <= bus.in_row_no + 1'b1;
                end
            end else begin
                r_seqErr <= 1'b1;
                r_expRow <= '0;
            end
        end
    end

    // Set and clear never target the same bank: fill needs it empty, drain needs it full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= '0;
        end else begin
            if (w_fillDone) begin
                r_full[r_wrBank] <= 1'b1;
            end
            if (w_drainDone) begin
                r_full[r_rdBank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rdBank   <= 1'b0;
            r_rdRow    <= '0;
            r_rdCol    <= '0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outLast  <= 1'b0;
        end else if (bus.enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_full[r_rdBank]) begin
                        r_state    <= ST_DRAIN;
                        r_outValid <= 1'b1;
                        r_rdRow    <= w_nextRow;
                        r_rdCol    <= w_nextCol;
                        r_outData  <= w_outElem;
                        r_outLast  <= w_nextLast;
                    end
                end
                ST_DRAIN: begin
                    if (w_handshake) begin
                        if (r_outLast) begin
                            r_rdBank <= ~r_rdBank;
                        end
                        if (r_outLast && !r_full[~r_rdBank]) begin
                            r_state    <= ST_IDLE;
                            r_outValid <= 1'b0;
                            r_rdRow    <= '0;
                            r_rdCol    <= '0;
                            r_outLast  <= 1'b0;
                        end else begin
                            r_rdRow   <= w_nextRow;
                            r_rdCol   <= w_nextCol;
                            r_outData <= w_outElem;
                            r_outLast <= w_nextLast;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_row   = r_rdRow;
    assign bus.out_col   = r_rdCol;
    assign bus.out_last  = r_outLast;
    assign bus.overflow  = r_overflow;
    assign bus.seq_err   = r_seqErr;

endmodule

`default_nettype wire

// File: tb/tb_matrix_sum_serializer.sv
// ============================================================================
// Module : tb_matrix_sum_serializer
// Brief  : Directed/random bench for matrix_sum_serializer against a
//          matrix-level queue model (MATRIX_SUM_SAT_EN aware).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_sum_serializer;
    import matrix_sum_serializer_pkg::*;

    localparam int IN_WIDTH = 10;
    localparam int ROWS     = 10;
    localparam int COLS     = 12;
    localparam int SW       = IN_WIDTH + 1;

    typedef struct {
        int v;
        int r;
        int c;
        bit last;
    } elem_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    matrix_sum_serializer_if #(.IN_WIDTH(IN_WIDTH), .COLS(COLS)) bus ();

    matrix_sum_serializer #(
        .IN_WIDTH (IN_WIDTH),
        .ROWS     (ROWS),
        .COLS     (COLS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    elem_t expQ[$];
    int    fill [ROWS][COLS];
    int    curRow [COLS];
    int    expRow;
    int    bufCnt;
    bit    mOvf;
    bit    mSeq;
    bit    tog;
    int    passCnt;
    int    checkCnt;
    int    drained;

    function automatic int expectOut(input int s);
`ifdef MATRIX_SUM_SAT_EN
        if (s > (1 << (IN_WIDTH-1)) - 1) return (1 << (IN_WIDTH-1)) - 1;
        if (s < -(1 << (IN_WIDTH-1)))    return -(1 << (IN_WIDTH-1));
        return s;
`else
        return s;
`endif
    endfunction

    function bit nextRdy(input int mode);
        if (mode == 1) begin
            tog = ~tog;
            return tog;
        end
        return (mode == 0);
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        checkCnt++;
        assert (obs === expv) passCnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic setRow(input int mode, input int r);
        for (int c = 0; c < COLS; c++) begin
            curRow[c] = (mode == 0) ? (r * 12 + c) : (int'($urandom_range(0, 2047)) - 1024);
        end
    endtask

    // One clock: apply inputs, advance the model, then compare after the edge.
    task automatic step(input bit en, input bit v, input int rowNo, input bit rdy);
        bit hs;
        bus.enable    = en;
        bus.in_valid  = v;
        bus.in_row_no = 4'(rowNo);
        bus.out_ready = rdy;
        for (int c = 0; c < COLS; c++) begin
            bus.in_sums[c*SW +: SW] = SW'(curRow[c]);
        end
        hs = en && bus.out_valid && rdy;
        if (en && v) begin
            if (bufCnt == 2) begin
                mOvf = 1'b1;
            end else if (rowNo == 0 || rowNo == expRow) begin
                for (int c = 0; c < COLS; c++) fill[rowNo][c] = curRow[c];
                if (rowNo == ROWS - 1) begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            expQ.push_back('{expectOut(fill[r][c]), r, c,
                                             (r == ROWS-1 && c == COLS-1)});
                        end
                    end
                    bufCnt++;
                    expRow = 0;
                end else begin
                    expRow = rowNo + 1;
                end
            end else begin
                mSeq   = 1'b1;
                expRow = 0;
            end
        end
        if (hs && expQ.size() > 0) begin
            if (expQ[0].last) bufCnt--;
            void'(expQ.pop_front());
            drained++;
        end
        @(posedge clk);
        #1;
        if (bus.out_valid) begin
            if (expQ.size() == 0) begin
                check("valid_with_nothing_buffered", int'(bus.out_valid), 0);
            end else begin
                check("data", int'($signed(bus.out_data)), expQ[0].v);
                check("row",  int'(bus.out_row),  expQ[0].r);
                check("col",  int'(bus.out_col),  expQ[0].c);
                check("last", int'(bus.out_last), int'(expQ[0].last));
            end
        end
        check("overflow", int'(bus.overflow), int'(mOvf));
        check("seq_err",  int'(bus.seq_err),  int'(mSeq));
    endtask

    task automatic doReset();
        reset         = 1'b1;
        bus.enable    = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        bufCnt = 0;
        expRow = 0;
        mOvf   = 1'b0;
        mSeq   = 1'b0;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data",  int'($signed(bus.out_data)), 0);
        check("rst_out_row",   int'(bus.out_row), 0);
        check("rst_out_col",   int'(bus.out_col), 0);
        check("rst_out_last",  int'(bus.out_last), 0);
        check("rst_overflow",  int'(bus.overflow), 0);
        check("rst_seq_err",   int'(bus.seq_err), 0);
    endtask

    task automatic sendMatrix(input int dataMode, input int rdyMode);
        for (int r = 0; r < ROWS; r++) begin
            setRow(dataMode, r);
            step(1'b1, 1'b1, r, nextRdy(rdyMode));
        end
    endtask

    task automatic drain(input int rdyMode, input int maxCycles);
        for (int i = 0; i < maxCycles && expQ.size() > 0; i++) begin
            step(1'b1, 1'b0, 0, nextRdy(rdyMode));
        end
        check("drain_left_over", expQ.size(), 0);
    endtask

    initial begin
        int start;
        passCnt = 0;
        checkCnt = 0;
        drained = 0;
        tog = 1'b0;
        bus.enable = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_row_no = '0;
        bus.in_sums = '0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < COLS; c++) curRow[c] = 0;

        doReset();

        // Ramp matrix, ready high: first element one cycle after the last row.
        for (int r = 0; r < ROWS - 1; r++) begin
            setRow(0, r);
            step(1'b1, 1'b1, r, 1'b1);
        end
        setRow(0, ROWS - 1);
        step(1'b1, 1'b1, ROWS - 1, 1'b1);
        check("lat_valid_at_N", int'(bus.out_valid), 0);
        step(1'b1, 1'b0, 0, 1'b1);
        check("lat_valid_at_N1", int'(bus.out_valid), 1);
        check("lat_first_data", int'($signed(bus.out_data)), 0);
        drain(0, 200);

        // Two random matrices back to back, ready toggling.
        sendMatrix(1, 1);
        sendMatrix(1, 1);
        drain(1, 1000);
        check("t2_overflow", int'(bus.overflow), 0);

        // Three matrices with ready low: the third is rejected.
        sendMatrix(1, 2);
        sendMatrix(1, 2);
        sendMatrix(1, 2);
        check("t3_overflow", int'(bus.overflow), 1);
        drain(0, 600);

        // Out-of-order row, then a clean matrix.
        setRow(1, 0); step(1'b1, 1'b1, 0, 1'b1);
        setRow(1, 1); step(1'b1, 1'b1, 1, 1'b1);
        setRow(1, 3); step(1'b1, 1'b1, 3, 1'b1);
        check("t4_seq_err", int'(bus.seq_err), 1);
        sendMatrix(1, 0);
        for (int i = 0; i < 6; i++) begin
            setRow(1, 5);
            step(1'b0, 1'b1, 5, 1'b1);
        end
        drain(0, 300);

        // Extreme sums in row 0.
        for (int r = 0; r < ROWS; r++) begin
            setRow(1, r);
            if (r == 0) begin
                curRow[0] = 1023;
                curRow[1] = -1024;
                curRow[2] = 511;
                curRow[3] = -512;
                curRow[4] = 512;
                curRow[5] = -513;
            end
            step(1'b1, 1'b1, r, 1'b0);
        end
        step(1'b1, 1'b0, 0, 1'b0);
`ifdef MATRIX_SUM_SAT_EN
        check("sat_pos_max", int'($signed(bus.out_data)), 511);
        step(1'b1, 1'b0, 0, 1'b1);
        check("sat_neg_min", int'($signed(bus.out_data)), -512);
`else
        check("pass_pos_max", int'($signed(bus.out_data)), 1023);
        step(1'b1, 1'b0, 0, 1'b1);
        check("pass_neg_min", int'($signed(bus.out_data)), -1024);
`endif
        drain(0, 300);

        // Reset after the 50th element leaves, then a fresh matrix.
        sendMatrix(1, 0);
        start = drained;
        for (int i = 0; i < 200 && (drained - start) < 50; i++) begin
            step(1'b1, 1'b0, 0, 1'b1);
        end
        check("t6_fifty_drained", drained - start, 50);
        doReset();
        sendMatrix(1, 0);
        step(1'b1, 1'b0, 0, 1'b0);
        check("t6_restart_row", int'(bus.out_row), 0);
        check("t6_restart_col", int'(bus.out_col), 0);
        drain(0, 300);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/matrix_sum_serializer.md
MATRIX_SUM_SERIALIZER -- requirements
Module: matrix_sum_serializer

Interface
REQ-001 Parameter IN_WIDTH, default 10, element width of the adder operands; each sum is IN_WIDTH+1 bits.
REQ-002 Parameter ROWS, default 10, vector sets (rows) per matrix.
REQ-003 Parameter COLS, default 12, elements per row.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 enable  in  1  when low, all state holds and in_valid is ignored.
REQ-007 in_valid  in  1  one-cycle strobe; a row of sums is present.
REQ-008 in_row_no  in  4  row index of the presented row, 0..ROWS-1.
REQ-009 in_sums  in  COLS*(IN_WIDTH+1)  packed signed sums; column c at bits [c*(IN_WIDTH+1) +: IN_WIDTH+1].
REQ-010 out_valid  out  1  out_data holds a valid element.
REQ-011 out_ready  in  1  downstream accepts the element when out_valid && out_ready.
REQ-012 out_data  out  OUT_W  signed element; OUT_W is set under Configuration.
REQ-013 out_row / out_col  out  4 / 4  indices of the current element.
REQ-014 out_last  out  1  high with the element at row ROWS-1, column COLS-1.
REQ-015 overflow  out  1  sticky; a row arrived while no bank was free.
REQ-016 seq_err  out  1  sticky; a row arrived with an unexpected index.

Function
REQ-017 The block has two row-major banks of ROWS x COLS sums; at any time one bank fills while the other drains.
REQ-018 Write side: exp_row counter and wr_bank pointer; an accepted row is written to wr_bank at row exp_row, and exp_row increments.
REQ-019 A row with in_row_no == 0 always restarts the fill at row 0 of wr_bank, discarding any partial fill; seq_err is not set for this case.
REQ-020 A row with in_row_no != exp_row and != 0 is dropped, sets seq_err, and sets exp_row to 0.
REQ-021 When row ROWS-1 is written, wr_bank is marked full, wr_bank toggles, and exp_row returns to 0.
REQ-022 When in_valid is high and wr_bank is still full (not yet drained), the row is dropped and overflow is set.
REQ-023 Read FSM has two states, IDLE and DRAIN; IDLE goes to DRAIN when rd_bank is full, with out_valid asserted the next cycle.
REQ-024 Latency: row ROWS-1 accepted at edge N with the reader IDLE gives out_valid=1 with element (0,0) after edge N+1.
REQ-025 In DRAIN, each handshake advances the column, then the row, in row-major order.
REQ-026 out_data, out_row, out_col and out_last stay stable while out_valid && !out_ready.
REQ-027 On the handshake with out_last high, rd_bank is marked empty and rd_bank toggles.
REQ-028 On that same handshake, the FSM goes directly to DRAIN if the other bank is full; otherwise it goes to IDLE.
REQ-029 A fill completing in the same cycle the drain of the other bank completes is legal; the full flags update independently.
REQ-030 A bank freed in a cycle is not writable until the next cycle; a row arriving in that cycle follows REQ-022.
REQ-031 Sustained throughput is one element per cycle with out_ready held high.

Reset
REQ-032 On reset: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, overflow=0, seq_err=0, exp_row=0, wr_bank=0, rd_bank=0, both banks empty, FSM=IDLE.
REQ-033 Reset mid-drain or mid-fill discards all buffered data; bank contents need not be cleared.
REQ-034 Reset has priority over enable.

Configuration
REQ-035 The feature is controlled by the macro MATRIX_SUM_SAT_EN.
REQ-036 With MATRIX_SUM_SAT_EN defined: OUT_W=IN_WIDTH, and each sum saturates to [-2^(IN_WIDTH-1), 2^(IN_WIDTH-1)-1] at the output.
REQ-037 Without MATRIX_SUM_SAT_EN: OUT_W=IN_WIDTH+1, and each sum passes through unmodified.

Structure
REQ-038 A shared package holds the ROWS/COLS defaults, the row and column index widths, and the read FSM state enum.
REQ-039 One sub-module, matrix_sum_bank, is a single ROWS x COLS storage with a row write port and an element read port, instantiated twice.

Verification
REQ-040 Reset, then rows 0..9 with sum(r,c)=r*12+c and out_ready=1: 120 elements in order; out_last only on (9,11) = 119; out_valid first seen 1 cycle after row 9.
REQ-041 Two back-to-back matrices, with out_ready toggling every cycle: 240 elements, no loss, data stable during stalls; overflow=0.
REQ-042 Three matrices back-to-back with out_ready=0: third matrix's first row sets overflow=1; first two matrices drain intact afterwards.
REQ-043 Rows 0,1,3: seq_err=1, row 3 dropped; then rows 0..9: the next matrix drains correctly.
REQ-044 IN_WIDTH=10, sum +1023, with the macro: output 511; without it: output 1023. Sum -1024 gives -512 / -1024.
REQ-045 Assert reset after the 50th drained element: the next cycle out_valid=0 and both flags are 0; a fresh matrix drains from (0,0).
